// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned CNT_W         = 4;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

  // Both requesting: prio wins. A lone requester wins regardless of prio.
  function automatic state_e arbitrate(input logic r0, input logic r1, input logic p);
    if (r0 && r1) return p ? G1 : G0;
    else if (r0)  return G0;
    else if (r1)  return G1;
    else          return IDLE;
  endfunction

endpackage

// File: rtl/mux_2x1_w.sv
// W-bit combinational 2:1 multiplexer: sel = 0 picks x0, sel = 1 picks x1.
module mux_2x1_w #(
  parameter int unsigned W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic [W-1:0] y
);

  always_comb begin
    y = sel ? x1 : x0;
  end

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two sources, with a
// per-grant burst limit and a registered output channel.
module mux_2x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         last0,
  input  logic         last1,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             gnt0_q, gnt1_q, sel_q;
  logic [W-1:0]     out_data_q;
  logic             out_valid_q;
  logic             beat, release_g;
  logic [W-1:0]     mux_y;

  mux_2x1_w #(.W(W)) u_mux (
    .sel (sel_q),
    .x0  (x0),
    .x1  (x1),
    .y   (mux_y)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    beat      = 1'b0;
    release_g = 1'b0;
    cnt_inc   = cnt_q + ONE;
    case (state_q)
      IDLE: state_d = arbitrate(req0, req1, prio_q);
      G0: begin
        beat      = req0;
        release_g = !req0 || last0 || (cnt_inc == MAX_CNT);
      end
      G1: begin
        beat      = req1;
        release_g = !req1 || last1 || (cnt_inc == MAX_CNT);
      end
      default: state_d = IDLE;
    endcase
    // Release hands priority to the other source and re-arbitrates in the
    // same cycle, so a switch costs no idle bubble.
    if (release_g) begin
      prio_d  = (state_q == G0);
      cnt_d   = '0;
      state_d = arbitrate(req0, req1, prio_d);
    end else if (beat) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= (state_d == G0);
      gnt1_q      <= (state_d == G1);
      sel_q       <= (state_d == G1);
      out_valid_q <= beat;
      if (beat) out_data_q <= mux_y;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
